mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles a grant may wait for ACCESS before the timeout flag sets.
REQ-002 Signal: CLK  in  1  clock, rising edge; nRST  in  1  reset, asynchronous, active-low.
REQ-003 Signal: iREN  in  1  instruction read request.
REQ-004 Signal: iaddr  in  32  instruction word address.
REQ-005 Signal: iload  out  32  instruction read data.
REQ-006 Signal: iwait  out  1  instruction not complete.
REQ-007 Signal: dREN  in  1  data read request.
REQ-008 Signal: dWEN  in  1  data write request.
REQ-009 Signal: daddr  in  32  data address.
REQ-010 Signal: dstore  in  32  write data.
REQ-011 Signal: dload  out  32  read data.
REQ-012 Signal: dwait  out  1  data not complete.
REQ-013 Signal: ramREN  out  1  RAM read.
REQ-014 Signal: ramWEN  out  1  RAM write.
REQ-015 Signal: ramaddr  out  32  RAM address.
REQ-016 Signal: ramstore  out  32  RAM write data.
REQ-017 Signal: ramload  in  32  RAM read data.
REQ-018 Signal: ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-019 Signal: timeout  out  1  sticky, a grant exceeded TIMEOUT.
REQ-020 Signal: icount, dcount  out  32 each  completed-transfer counters.

Function
REQ-021 FSM states IDLE, GNT_I, GNT_D; grant state registered.
REQ-022 IDLE: only dREN|dWEN -> GNT_D; only iREN -> GNT_I; both pending -> GNT_D unless the last completed grant was D, then GNT_I (alternation, no starvation).
REQ-023 In IDLE: ramREN=ramWEN=0, iwait=iREN, dwait=dREN|dWEN.
REQ-024 GNT_I: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0; dwait=dREN|dWEN.
REQ-025 GNT_D: ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0 (write wins if both set); else ramREN=1.
REQ-026 Completion: ramstate==ACCESS in a grant state -> granted wait=0 combinationally that cycle, iload/dload=ramload that cycle, FSM -> IDLE at the next edge.
REQ-027 Minimum latency: request at edge N is granted after edge N+1, completes earliest in cycle N+1; back-to-back transfers insert one IDLE cycle.
REQ-028 iload/dload are 0 whenever the matching requester is not completing.
REQ-029 Request withdrawn mid-grant (granted REN/WEN low) -> RAM strobes drop combinationally, FSM -> IDLE next edge, no count.
REQ-030 ramstate BUSY/FREE/ERROR in a grant state -> hold the grant, wait stays 1.
REQ-031 Per-grant wait counter (8+ bits, saturating), cleared on grant entry; reaching TIMEOUT sets timeout; only reset clears it; the grant is not aborted.
REQ-032 Addresses are passed through unmodified, including the low 2 bits.

Reset
REQ-033 Reset -> IDLE, last-grant=I (first conflict goes to D), timeout=0, wait counter=0, icount=dcount=0; all outputs take IDLE values immediately.
REQ-034 Reset asserted mid-grant aborts the transfer at once; RAM strobes drop asynchronously.

Configuration
REQ-035 Macro MEM_ARBITER_PERF_EN: if defined, icount/dcount increment by 1 on each completed I/D transfer, wrapping 0xFFFFFFFF -> 0.
REQ-036 If not defined, icount and dcount are tied to 0 and no counter flops exist.

Structure
REQ-037 ramstate_t enum (FREE/BUSY/ACCESS/ERROR) and word_t are defined in cpu_types_pkg.
REQ-038 arb_state_t stays local to the module.
REQ-039 One sub-module: arb_timer (per-grant wait counter plus sticky timeout flag).

Verification
REQ-040 iREN=1, iaddr=0x40, ramstate BUSY x2 then ACCESS, ramload=0x8C010004 -> ramREN=1/ramaddr=0x40 for 3 cycles, iload=0x8C010004 and iwait=0 in the third.
REQ-041 iREN and dREN asserted together in IDLE -> D served first, then I, then on the next conflict D again.
REQ-042 dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-043 TIMEOUT=4, ramstate held BUSY for 10 cycles -> timeout=1 after 4 grant cycles, stays 1, grant held; nRST low -> timeout=0, FSM IDLE.
REQ-044 iREN dropped in the second grant cycle -> ramREN=0 the same cycle, FSM IDLE next edge, icount unchanged.
REQ-045 With MEM_ARBITER_PERF_EN: 3 I and 2 D transfers -> icount=3, dcount=2; without the macro both read 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types: word_t and the RAM state encoding
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Response state reported by the RAM each cycle
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - instruction/data requester and RAM bus bundle for mem_arbiter
interface mem_arbiter_if
  import cpu_types_pkg::*;
  ;

  // Instruction requester
  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;

  // Data requester
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;

  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  // The arbiter itself
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  // The requesters plus RAM that surround the arbiter
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_timer.sv
// rtl/mem_arbiter_timer.sv - arb_timer: per-grant wait counter with sticky timeout flag
module arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic run,
  output logic timeout
);

  localparam int CLOG = $clog2(TIMEOUT + 1);
  localparam int W    = (CLOG > 8) ? CLOG : 8;
  localparam logic [W:0] LIMIT = (W+1)'(TIMEOUT);

  logic [W-1:0] cnt;
  logic [W:0]   cnt_inc;

  // one extra bit so the compare never wraps when the counter is saturated
  assign cnt_inc = {1'b0, cnt} + 1'b1;

  // counts waiting grant cycles; timeout is sticky until reset, the grant continues
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
      if (cnt_inc >= LIMIT) timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester RAM arbiter with alternating priority; MEM_ARBITER_PERF_EN enables transfer counters
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  mem_arbiter_if.slave      bus,
  output logic              timeout,
  output word_t             icount,
  output word_t             dcount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  arb_state_t state, next_state;
  logic       last_d;
  logic       d_req;
  logic       i_done, d_done;
  logic       access;

  assign d_req  = bus.dREN | bus.dWEN;
  assign access = (bus.ramstate == ACCESS);

  // grant state and the alternation bit; last_d reset to I so the first conflict goes to D
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state <= next_state;
      if (d_done)      last_d <= 1'b1;
      else if (i_done) last_d <= 1'b0;
    end
  end

  // next-state and all bus outputs; strobes follow the live request so withdrawal drops them at once
  always_comb begin
    next_state   = state;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = bus.iREN;
    bus.dwait    = d_req;
    bus.iload    = '0;
    bus.dload    = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!bus.iREN || !last_d)) next_state = GNT_D;
        else if (bus.iREN)                   next_state = GNT_I;
      end
      GNT_I: begin
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          next_state = IDLE;
        end else begin
          bus.ramREN = 1'b1;
          if (access) begin
            bus.iwait  = 1'b0;
            bus.iload  = bus.ramload;
            i_done     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      GNT_D: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          // a write wins when both strobes are set
          if (bus.dWEN) bus.ramWEN = 1'b1;
          else          bus.ramREN = 1'b1;
          if (access) begin
            bus.dwait  = 1'b0;
            bus.dload  = bus.ramload;
            d_done     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (state == IDLE),
    .run     ((state != IDLE) && !access),
    .timeout (timeout)
  );

`ifdef MEM_ARBITER_PERF_EN
  // completed-transfer counters, wrapping naturally at 32 bits
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      if (i_done) icount <= icount + 32'd1;
      if (d_done) dcount <= dcount + 32'd1;
    end
  end
`else
  assign icount = '0;
  assign dcount = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    logic      iren;
    word_t     iaddr;
    logic      dren;
    logic      dwen;
    word_t     daddr;
    word_t     dstore;
    ramstate_t rs;
    word_t     rload;
    logic      e_ren;
    logic      e_wen;
    word_t     e_addr;
    word_t     e_store;
    logic      e_iwait;
    logic      e_dwait;
    word_t     e_iload;
    word_t     e_dload;
  } vec_t;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  timeout;
  word_t icount, dcount;
  int    checks = 0;
  int    fails  = 0;
  vec_t  v [21];
  logic [131:0] act, exp_v;
  word_t exp_i, exp_d;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .bus     (bus),
    .timeout (timeout),
    .icount  (icount),
    .dcount  (dcount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [131:0] a, input logic [131:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  function automatic logic [131:0] outs();
    return {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore,
            bus.iwait, bus.dwait, bus.iload, bus.dload};
  endfunction

  initial begin
    // conflicts from reset: D, then I, then D again; low address bits pass through
    v[0]  = '{1, 32'h47, 1, 0, 32'h203, 32'h12345678, FREE,   32'hA5A5A5A5, 0, 0, 32'h0,   32'h0,        1, 1, 32'h0,        32'h0};
    v[1]  = '{1, 32'h47, 1, 0, 32'h203, 32'h12345678, ACCESS, 32'hA5A5A5A5, 1, 0, 32'h203, 32'h12345678, 1, 0, 32'h0,        32'hA5A5A5A5};
    v[2]  = '{1, 32'h47, 1, 0, 32'h203, 32'h12345678, FREE,   32'hA5A5A5A5, 0, 0, 32'h0,   32'h0,        1, 1, 32'h0,        32'h0};
    v[3]  = '{1, 32'h47, 1, 0, 32'h203, 32'h12345678, ACCESS, 32'h5A5A5A5A, 1, 0, 32'h47,  32'h0,        0, 1, 32'h5A5A5A5A, 32'h0};
    v[4]  = '{1, 32'h47, 1, 0, 32'h203, 32'h12345678, FREE,   32'h5A5A5A5A, 0, 0, 32'h0,   32'h0,        1, 1, 32'h0,        32'h0};
    v[5]  = '{1, 32'h47, 1, 0, 32'h203, 32'h12345678, ACCESS, 32'h0F0F0F0F, 1, 0, 32'h203, 32'h12345678, 1, 0, 32'h0,        32'h0F0F0F0F};
    v[6]  = '{0, 32'h47, 0, 0, 32'h203, 32'h12345678, FREE,   32'h0F0F0F0F, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        32'h0};
    // instruction read with two BUSY cycles, then idle with stale ramload
    v[7]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        BUSY,   32'h0,        0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        32'h0};
    v[8]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        BUSY,   32'h0,        1, 0, 32'h40,  32'h0,        1, 0, 32'h0,        32'h0};
    v[9]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        BUSY,   32'h0,        1, 0, 32'h40,  32'h0,        1, 0, 32'h0,        32'h0};
    v[10] = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        ACCESS, 32'h8C010004, 1, 0, 32'h40,  32'h0,        0, 0, 32'h8C010004, 32'h0};
    v[11] = '{0, 32'h40, 0, 0, 32'h0,   32'h0,        FREE,   32'h8C010004, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        32'h0};
    // write with both strobes set
    v[12] = '{0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, FREE,   32'h0,        0, 0, 32'h0,   32'h0,        0, 1, 32'h0,        32'h0};
    v[13] = '{0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, ACCESS, 32'h11111111, 0, 1, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        32'h11111111};
    v[14] = '{0, 32'h0,  0, 0, 32'h100, 32'hDEADBEEF, FREE,   32'h11111111, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        32'h0};
    // instruction request withdrawn in second grant cycle; next cycle must be IDLE (ramaddr 0)
    v[15] = '{1, 32'h80, 0, 0, 32'h0,   32'h0,        BUSY,   32'h0,        0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        32'h0};
    v[16] = '{1, 32'h80, 0, 0, 32'h0,   32'h0,        BUSY,   32'h0,        1, 0, 32'h80,  32'h0,        1, 0, 32'h0,        32'h0};
    v[17] = '{0, 32'h80, 0, 0, 32'h0,   32'h0,        BUSY,   32'h0,        0, 0, 32'h80,  32'h0,        0, 0, 32'h0,        32'h0};
    v[18] = '{0, 32'h80, 1, 0, 32'h300, 32'h0,        FREE,   32'h0,        0, 0, 32'h0,   32'h0,        0, 1, 32'h0,        32'h0};
    v[19] = '{0, 32'h80, 1, 0, 32'h300, 32'h0,        ACCESS, 32'h22222222, 1, 0, 32'h300, 32'h0,        0, 0, 32'h0,        32'h22222222};
    v[20] = '{0, 32'h80, 0, 0, 32'h300, 32'h0,        FREE,   32'h22222222, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        32'h0};

`ifdef MEM_ARBITER_PERF_EN
    exp_i = 32'd2;
    exp_d = 32'd4;
`else
    exp_i = 32'd0;
    exp_d = 32'd0;
`endif

    // reset with both requests pending: IDLE outputs
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h0; bus.dREN = 1'b1; bus.dWEN = 1'b0;
    bus.daddr = 32'h0; bus.dstore = 32'h0; bus.ramload = 32'h0; bus.ramstate = FREE;
    #3;
    check("reset_outputs", outs(), {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0});
    check("reset_flags", {67'h0, timeout, icount, dcount}, 132'h0);
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge CLK);
      bus.iREN = v[i].iren;  bus.iaddr = v[i].iaddr;
      bus.dREN = v[i].dren;  bus.dWEN = v[i].dwen;
      bus.daddr = v[i].daddr; bus.dstore = v[i].dstore;
      bus.ramstate = v[i].rs; bus.ramload = v[i].rload;
      #1;
      act   = outs();
      exp_v = {v[i].e_ren, v[i].e_wen, v[i].e_addr, v[i].e_store,
               v[i].e_iwait, v[i].e_dwait, v[i].e_iload, v[i].e_dload};
      check($sformatf("vec%0d", i), act, exp_v);
    end

    check("icount", {100'h0, icount}, {100'h0, exp_i});
    check("dcount", {100'h0, dcount}, {100'h0, exp_d});
    check("no_timeout_yet", {131'h0, timeout}, 132'h0);

    // grant held in BUSY: timeout after four waiting cycles, grant not aborted
    @(negedge CLK);
    bus.iREN = 1'b1; bus.iaddr = 32'h10; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.ramstate = BUSY; bus.ramload = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      #1;
      check($sformatf("tmo_cycle%0d", k),
            {96'h0, bus.ramREN, bus.iwait, timeout, bus.ramaddr},
            {96'h0, 1'b1, 1'b1, (k >= 5), 32'h10});
    end

    // reset mid-grant: strobes and timeout drop without a clock edge
    nRST = 1'b0;
    #1;
    check("reset_mid_grant", {96'h0, bus.ramREN, bus.iwait, timeout, bus.ramaddr},
          {96'h0, 1'b0, 1'b1, 1'b0, 32'h0});
    @(negedge CLK);
    bus.iREN = 1'b0; bus.ramstate = FREE;
    nRST = 1'b1;
    @(negedge CLK);
    #1;
    check("post_reset_idle", outs(), 132'h0);
    check("post_reset_flags", {67'h0, timeout, icount, dcount}, 132'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
